// File: rtl/mips_mem_responder_if.sv
// ============================================================================
// Module      : mips_mem_responder_if
// Description : Core-side memory port and console drain bundle of the
//               MIPS memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_mem_responder_if;
    logic [31:0] mem_addr;      // byte address from core
    logic [31:0] mem_wr_data;   // write data from core
    logic        mem_wr_ena;    // write strobe
    logic [31:0] mem_rd_data;   // combinational read data
    logic        con_valid;     // console FIFO non-empty
    logic [7:0]  con_data;      // console FIFO head byte
    logic        con_ready;     // consumer accepts head

    // core/consumer side
    modport master (
        output mem_addr, mem_wr_data, mem_wr_ena, con_ready,
        input  mem_rd_data, con_valid, con_data
    );

    // responder side
    modport slave (
        input  mem_addr, mem_wr_data, mem_wr_ena, con_ready,
        output mem_rd_data, con_valid, con_data
    );
endinterface

`default_nettype wire

// File: rtl/mips_mem_responder.sv
// ============================================================================
// Module      : mips_mem_responder
// Description : Memory-side responder for the multicycle MIPS unified port.
//               Word RAM with zero-latency reads plus an MMIO window holding
//               a cycle counter, a console TX FIFO and a sticky halt register.
//               Optional macro MEM_ALIGN_CHECK_EN builds the sticky
//               misaligned-access detector driving align_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rstb,
    mips_mem_responder_if.slave   bus,
    output logic                  halt,
    output logic [7:0]            halt_code,
    output logic                  align_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(FIFO_DEPTH);

    // MMIO register word offsets (byte offset >> 2)
    localparam logic [13:0] c_ofs_cycle    = 14'h0000;
    localparam logic [13:0] c_ofs_con_data = 14'h0001;
    localparam logic [13:0] c_ofs_status   = 14'h0002;
    localparam logic [13:0] c_ofs_halt     = 14'h0003;

    logic [31:0]       ram_q  [2**ADDR_WIDTH];
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [31:0]       cycle_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              ovf_q;
    logic              halt_q;
    logic [7:0]        halt_code_q;

    // address decode; the low two address bits never select data
    logic                  w_is_mmio;
    logic [13:0]           w_ofs;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    assign w_is_mmio = (bus.mem_addr[31:16] == MMIO_BASE[31:16]);
    assign w_ofs     = bus.mem_addr[15:2];
    assign w_ram_idx = bus.mem_addr[ADDR_WIDTH+1:2];

    logic w_ram_we, w_push_req, w_halt_we;
    assign w_ram_we   = bus.mem_wr_ena && !w_is_mmio;
    assign w_push_req = bus.mem_wr_ena && w_is_mmio && (w_ofs == c_ofs_con_data);
    assign w_halt_we  = bus.mem_wr_ena && w_is_mmio && (w_ofs == c_ofs_halt);

    // FIFO handshake: a full FIFO still takes a byte when its head leaves
    logic w_full, w_empty, w_pop, w_push;
    assign w_full  = (count_q == c_depth_cnt);
    assign w_empty = (count_q == '0);
    assign w_pop   = !w_empty && bus.con_ready;
    assign w_push  = w_push_req && (!w_full || w_pop);

    assign bus.con_valid = !w_empty;
    assign bus.con_data  = w_empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign halt          = halt_q;
    assign halt_code     = halt_code_q;

    // count only moves when exactly one of push/pop happens
    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            ram_q[w_ram_idx] <= bus.mem_wr_data;
        end
    end

    // FIFO storage; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= bus.mem_wr_data[7:0];
        end
    end

    // control state: counter, FIFO pointers, overflow and halt
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cycle_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            halt_q      <= 1'b0;
            halt_code_q <= 8'h00;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            count_q <= count_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push_req && !w_push) begin
                ovf_q <= 1'b1;
            end
            if (w_halt_we && !halt_q) begin
                halt_q      <= 1'b1;
                halt_code_q <= bus.mem_wr_data[7:0];
            end
        end
    end

    // count field is 8 bits wide; a 256-deep full FIFO reports 0 there
    logic [7:0] w_cnt_byte;
    assign w_cnt_byte = 8'(count_q);

    // zero-latency read mux
    always_comb begin
        bus.mem_rd_data = 32'h0;
        if (w_is_mmio) begin
            case (w_ofs)
                c_ofs_cycle:  bus.mem_rd_data = cycle_q;
                c_ofs_status: bus.mem_rd_data = {16'h0, w_cnt_byte, 5'b0,
                                                 ovf_q, w_empty, w_full};
                c_ofs_halt:   bus.mem_rd_data = {23'b0, halt_q, halt_code_q};
                default:      bus.mem_rd_data = 32'h0;
            endcase
        end else begin
            bus.mem_rd_data = ram_q[w_ram_idx];
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic align_q;
    logic w_misaligned;
    assign w_misaligned = (bus.mem_addr[1:0] != 2'b00);

    // sticky flag for misaligned writes and misaligned MMIO reads
    always_ff @(posedge clk) begin
        if (!rstb) begin
            align_q <= 1'b0;
        end else if (w_misaligned && (bus.mem_wr_ena || w_is_mmio)) begin
            align_q <= 1'b1;
        end
    end

    assign align_err = align_q;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^bus.mem_addr[1:0];
    assign align_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_responder.sv
// ============================================================================
// Module      : tb_mips_mem_responder
// Description : Scoreboard bench for mips_mem_responder. Stimulus pushes
//               expected values; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mem_responder;

    logic       clk = 1'b0;
    logic       rstb;
    logic       halt;
    logic [7:0] halt_code;
    logic       align_err;

    always #5 clk = ~clk;

    mips_mem_responder_if bus ();

    mips_mem_responder #(
        .ADDR_WIDTH (10),
        .MMIO_BASE  (32'hFFFF0000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .bus       (bus),
        .halt      (halt),
        .halt_code (halt_code),
        .align_err (align_err)
    );

    localparam int SEL_RD     = 0;
    localparam int SEL_HALT   = 1;
    localparam int SEL_CODE   = 2;
    localparam int SEL_ALIGN  = 3;
    localparam int SEL_CVALID = 4;
    localparam int SEL_CDATA  = 5;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF0000;
    localparam logic [31:0] A_CON    = 32'hFFFF0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF0008;
    localparam logic [31:0] A_HALT   = 32'hFFFF000C;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t       chk_q[$];
    logic [7:0] con_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       end_req = 1'b0;
    logic       done    = 1'b0;

    // monitor: compares queued probes and every accepted console byte
    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [31:0] act;
        logic [7:0]  eb;
        while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            case (c.sel)
                SEL_RD:     act = bus.mem_rd_data;
                SEL_HALT:   act = {31'b0, halt};
                SEL_CODE:   act = {24'b0, halt_code};
                SEL_ALIGN:  act = {31'b0, align_err};
                SEL_CVALID: act = {31'b0, bus.con_valid};
                SEL_CDATA:  act = {24'b0, bus.con_data};
                default:    act = 'x;
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %08h, expected %08h", c.name, act, c.exp);
            end
        end
        if (bus.con_valid === 1'b1 && bus.con_ready === 1'b1) begin
            checks++;
            if (con_q.size() == 0) begin
                errors++;
                $display("FAIL con_pop: got byte %02h, expected no byte", bus.con_data);
            end else begin
                eb = con_q.pop_front();
                if (bus.con_data !== eb) begin
                    errors++;
                    $display("FAIL con_pop: got %02h, expected %02h", bus.con_data, eb);
                end
            end
        end
        if (end_req && !done) begin
            checks++;
            if (con_q.size() != 0) begin
                errors++;
                $display("FAIL con_drain: %0d bytes still pending, expected 0", con_q.size());
            end
            done = 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus.mem_addr   = a;
        bus.mem_wr_ena = 1'b0;
        expect_now(name, SEL_RD, exp);
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_addr    = a;
        bus.mem_wr_data = d;
        bus.mem_wr_ena  = 1'b1;
        tick();
        bus.mem_wr_ena  = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rstb            = 1'b0;
        bus.mem_addr    = 32'h0;
        bus.mem_wr_data = 32'h0;
        bus.mem_wr_ena  = 1'b0;
        bus.con_ready   = 1'b0;
        tick();
        tick();

        // reset state
        expect_now("rst_halt",      SEL_HALT,   32'h0);
        expect_now("rst_halt_code", SEL_CODE,   32'h0);
        expect_now("rst_align",     SEL_ALIGN,  32'h0);
        expect_now("rst_con_valid", SEL_CVALID, 32'h0);
        expect_now("rst_con_data",  SEL_CDATA,  32'h0);
        rd(A_CYCLE, 32'd0, "cycle_in_reset");

        // cycle counter: 0 at first non-reset cycle, 5 five edges later
        rstb = 1'b1;
        rd(A_CYCLE, 32'd0, "cycle_n");
        repeat (4) tick();
        rd(A_CYCLE, 32'd5, "cycle_n_plus_5");
        rd(A_STATUS, 32'h0000_0002, "status_empty");

        // RAM write/read, aliasing, same-cycle read returns old word
        wr(32'h0000_0010, 32'hDEADBEEF);
        rd(32'h0000_0010, 32'hDEADBEEF, "ram_rd");
        rd(32'h0000_1010, 32'hDEADBEEF, "ram_alias");
        bus.mem_addr    = 32'h0000_0010;
        bus.mem_wr_data = 32'h1234_5678;
        bus.mem_wr_ena  = 1'b1;
        expect_now("ram_rd_old_word", SEL_RD, 32'hDEADBEEF);
        tick();
        bus.mem_wr_ena  = 1'b0;
        rd(32'h0000_0010, 32'h1234_5678, "ram_rd_new_word");
        rd(32'hFFFF_0010, 32'h0, "mmio_unmapped");
        rd(A_CON, 32'h0, "con_data_reads_zero");

        // overflow: nine pushes into an eight-deep FIFO, last one dropped
        for (int i = 0; i < 9; i++) begin
            wr(A_CON, 32'h41 + i);
            if (i < 8) con_q.push_back(8'(8'h41 + i));
        end
        expect_now("con_head_held",  SEL_CDATA,  32'h41);
        expect_now("con_valid_full", SEL_CVALID, 32'h1);
        rd(A_STATUS, 32'h0000_0805, "status_full_ovf");
        bus.con_ready = 1'b1;
        repeat (8) tick();
        expect_now("drain_done", SEL_CVALID, 32'h0);
        tick();
        bus.con_ready = 1'b0;
        rd(A_STATUS, 32'h0000_0006, "status_ovf_sticky");

        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        rd(A_STATUS, 32'h0000_0002, "status_after_reset");

        // full FIFO with simultaneous pop and push: push accepted
        for (int i = 0; i < 8; i++) begin
            wr(A_CON, 32'h50 + i);
            con_q.push_back(8'(8'h50 + i));
        end
        rd(A_STATUS, 32'h0000_0801, "status_full_no_ovf");
        bus.mem_addr    = A_CON;
        bus.mem_wr_data = 32'h5A;
        bus.mem_wr_ena  = 1'b1;
        bus.con_ready   = 1'b1;
        con_q.push_back(8'h5A);
        tick();
        bus.mem_wr_ena  = 1'b0;
        bus.con_ready   = 1'b0;
        rd(A_STATUS, 32'h0000_0801, "status_push_pop_full");
        bus.con_ready = 1'b1;
        repeat (8) tick();
        bus.con_ready = 1'b0;
        expect_now("drain2_done", SEL_CVALID, 32'h0);
        tick();
        rd(A_STATUS, 32'h0000_0002, "status_no_ovf");

        // halt is sticky, code frozen after the first write
        wr(A_HALT, 32'h2A);
        expect_now("halt_set",  SEL_HALT, 32'h1);
        expect_now("halt_code", SEL_CODE, 32'h2A);
        rd(A_HALT, 32'h0000_012A, "halt_reg_read");
        wr(A_HALT, 32'h07);
        expect_now("halt_still_set",   SEL_HALT, 32'h1);
        expect_now("halt_code_sticky", SEL_CODE, 32'h2A);
        tick();

        // bytes queued before a reset are lost
        wr(A_CON, 32'h77);
        wr(A_CON, 32'h78);
        expect_now("con_valid_prereset", SEL_CVALID, 32'h1);
        tick();
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        expect_now("halt_cleared",      SEL_HALT,   32'h0);
        expect_now("halt_code_cleared", SEL_CODE,   32'h0);
        expect_now("fifo_cleared",      SEL_CVALID, 32'h0);
        tick();
        rd(A_CYCLE, 32'd1, "cycle_after_reset");

        // counter wraps from all-ones to zero
        force dut.cycle_q = 32'hFFFF_FFFF;
        bus.mem_addr = A_CYCLE;
        expect_now("cycle_forced", SEL_RD, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        release dut.cycle_q;
        tick();
        rd(A_CYCLE, 32'h0, "cycle_wrap");

        // misaligned write still lands in ram[4]
        wr(32'h0000_0012, 32'hCAFE_F00D);
`ifdef MEM_ALIGN_CHECK_EN
        expect_now("align_err", SEL_ALIGN, 32'h1);
`else
        expect_now("align_err", SEL_ALIGN, 32'h0);
`endif
        tick();
        rd(32'h0000_0010, 32'hCAFE_F00D, "ram_misaligned_write");

        end_req = 1'b1;
        for (int i = 0; i < 4 && !done; i++) tick();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL end_handshake: monitor did not finish, expected done");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
